// File: rtl/wb_cmd_master.sv
// wb_cmd_master: Wishbone classic single-access initiator.
// Takes read/write commands on a valid/ready port, runs one Wishbone
// cycle per command with an optional stb-high timeout, and returns
// read data or a timeout error on a valid/ready response port.
// Every output is driven straight from a register.

module wb_cmd_master #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  // command port
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_we,
  input  logic [DATA_W/8-1:0]   cmd_sel,
  input  logic [ADDR_W-1:0]     cmd_adr,
  input  logic [DATA_W-1:0]     cmd_dat,
  // response port
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_W-1:0]     rsp_dat,
  output logic                  rsp_err,
  // Wishbone initiator side
  output logic                  wbm_cyc_o,
  output logic                  wbm_stb_o,
  output logic                  wbm_we_o,
  output logic [DATA_W/8-1:0]   wbm_sel_o,
  output logic [ADDR_W-1:0]     wbm_adr_o,
  output logic [DATA_W-1:0]     wbm_dat_o,
  input  logic                  wbm_ack_i,
  input  logic [DATA_W-1:0]     wbm_dat_i,
  // status
  output logic                  busy
);

  // Last counter value before the bus cycle is abandoned. Only
  // meaningful when TIMEOUT is non-zero.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
  localparam bit              TO_EN   = (TIMEOUT != 0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t                state_r;
  state_t                state_s;

  logic                  cmd_ready_r;
  logic                  rsp_valid_r;
  logic                  busy_r;
  logic [DATA_W-1:0]     rsp_dat_r,  rsp_dat_s;
  logic                  rsp_err_r,  rsp_err_s;
  logic                  cyc_r,      cyc_s;
  logic                  stb_r,      stb_s;
  logic                  we_r,       we_s;
  logic [DATA_W/8-1:0]   sel_r,      sel_s;
  logic [ADDR_W-1:0]     adr_r,      adr_s;
  logic [DATA_W-1:0]     dat_o_r,    dat_o_s;
  logic [TO_W-1:0]       cnt_r,      cnt_s;

  logic                  accept_s;
  logic                  timeout_s;
  logic                  rsp_done_s;

  // Handshake and abort qualifiers shared by the next-state and output logic.
  always_comb begin
    accept_s   = cmd_valid & cmd_ready_r;
    rsp_done_s = rsp_valid_r & rsp_ready;
    if (TO_EN) begin
      timeout_s = (cnt_r == TO_LAST);
    end else begin
      timeout_s = 1'b0;
    end
  end

  // State register; reset drops the in-flight transaction without a response.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode; ack takes priority over a coincident timeout.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_s = ST_BUS;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_BUS: begin
        if (wbm_ack_i) begin
          state_s = ST_RESP;
        end else if (timeout_s) begin
          state_s = ST_RESP;
        end else begin
          state_s = ST_BUS;
        end
      end
      ST_RESP: begin
        if (rsp_done_s) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_RESP;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Next values of the bus and response registers; everything holds by default.
  always_comb begin
    rsp_dat_s = rsp_dat_r;
    rsp_err_s = rsp_err_r;
    cyc_s     = cyc_r;
    stb_s     = stb_r;
    we_s      = we_r;
    sel_s     = sel_r;
    adr_s     = adr_r;
    dat_o_s   = dat_o_r;
    cnt_s     = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          // Write data is forwarded for reads too; the slave ignores it.
          cyc_s   = 1'b1;
          stb_s   = 1'b1;
          we_s    = cmd_we;
          sel_s   = cmd_sel;
          adr_s   = cmd_adr;
          dat_o_s = cmd_dat;
          cnt_s   = '0;
        end else begin
          cnt_s   = cnt_r;
        end
      end
      ST_BUS: begin
        if (wbm_ack_i) begin
          cyc_s     = 1'b0;
          stb_s     = 1'b0;
          rsp_err_s = 1'b0;
          if (we_r) begin
            rsp_dat_s = '0;
          end else begin
            rsp_dat_s = wbm_dat_i;
          end
        end else if (timeout_s) begin
          cyc_s     = 1'b0;
          stb_s     = 1'b0;
          rsp_err_s = 1'b1;
          rsp_dat_s = '0;
        end else begin
          cnt_s     = cnt_r + TO_W'(1);
        end
      end
      ST_RESP: begin
        // Response fields stay frozen until the consumer takes them.
        rsp_dat_s = rsp_dat_r;
        rsp_err_s = rsp_err_r;
      end
      default: begin
        cyc_s = 1'b0;
        stb_s = 1'b0;
      end
    endcase
  end

  // Output registers; handshake flags mirror the state being entered.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      cmd_ready_r <= 1'b0;
      rsp_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      rsp_dat_r   <= '0;
      rsp_err_r   <= 1'b0;
      cyc_r       <= 1'b0;
      stb_r       <= 1'b0;
      we_r        <= 1'b0;
      sel_r       <= '0;
      adr_r       <= '0;
      dat_o_r     <= '0;
      cnt_r       <= '0;
    end else begin
      cmd_ready_r <= (state_s == ST_IDLE);
      rsp_valid_r <= (state_s == ST_RESP);
      busy_r      <= (state_s != ST_IDLE);
      rsp_dat_r   <= rsp_dat_s;
      rsp_err_r   <= rsp_err_s;
      cyc_r       <= cyc_s;
      stb_r       <= stb_s;
      we_r        <= we_s;
      sel_r       <= sel_s;
      adr_r       <= adr_s;
      dat_o_r     <= dat_o_s;
      cnt_r       <= cnt_s;
    end
  end

  assign cmd_ready = cmd_ready_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_dat   = rsp_dat_r;
  assign rsp_err   = rsp_err_r;
  assign wbm_cyc_o = cyc_r;
  assign wbm_stb_o = stb_r;
  assign wbm_we_o  = we_r;
  assign wbm_sel_o = sel_r;
  assign wbm_adr_o = adr_r;
  assign wbm_dat_o = dat_o_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_wb_cmd_master.sv
// Directed self-checking bench for wb_cmd_master (TIMEOUT = 8).
// Inputs change and outputs are sampled 1 time unit after each rising edge.

module tb_wb_cmd_master;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [3:0]  cmd_sel;
  logic [31:0] cmd_adr;
  logic [31:0] cmd_dat;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_dat;
  logic        rsp_err;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] adr;
  logic [31:0] dat_o;
  logic        ack;
  logic [31:0] dat_i;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  wb_cmd_master #(
    .ADDR_W (32),
    .DATA_W (32),
    .TIMEOUT(8),
    .TO_W   (8)
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_we   (cmd_we),
    .cmd_sel  (cmd_sel),
    .cmd_adr  (cmd_adr),
    .cmd_dat  (cmd_dat),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_dat  (rsp_dat),
    .rsp_err  (rsp_err),
    .wbm_cyc_o(cyc),
    .wbm_stb_o(stb),
    .wbm_we_o (we),
    .wbm_sel_o(sel),
    .wbm_adr_o(adr),
    .wbm_dat_o(dat_o),
    .wbm_ack_i(ack),
    .wbm_dat_i(dat_i),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a command for one edge; returns in cycle 1 of the bus cycle.
  task automatic issue(input logic w, input logic [3:0] s, input logic [31:0] a, input logic [31:0] d);
    cmd_valid = 1'b1;
    cmd_we    = w;
    cmd_sel   = s;
    cmd_adr   = a;
    cmd_dat   = d;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_we    = 1'b0;
    cmd_sel   = 4'h0;
    cmd_adr   = 32'h0;
    cmd_dat   = 32'h0;
    rsp_ready = 1'b0;
    ack       = 1'b0;
    dat_i     = 32'h0;

    // ---- reset state ----
    tick();
    tick();
    chk("rst_cmd_ready", cmd_ready, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_cyc_stb", {cyc, stb, we}, 3'b000);
    chk("rst_adr", adr, 32'h0);
    chk("rst_dat_o", dat_o, 32'h0);
    chk("rst_rsp", {rsp_err, rsp_dat}, 33'h0);
    chk("rst_busy", busy, 1'b0);
    rst = 1'b0;
    chk("rel_ready_low", cmd_ready, 1'b0);
    tick();
    chk("rel_ready_high", cmd_ready, 1'b1);

    // ---- 1: zero-wait write ----
    issue(1'b1, 4'hF, 32'h3000_0004, 32'hDEAD_BEEF);
    chk("t1_cyc_stb", {cyc, stb, we}, 3'b111);
    chk("t1_adr", adr, 32'h3000_0004);
    chk("t1_dat_o", dat_o, 32'hDEAD_BEEF);
    chk("t1_sel", sel, 4'hF);
    chk("t1_busy_nordy", {busy, cmd_ready}, 2'b10);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("t1_cyc_low", {cyc, stb}, 2'b00);
    chk("t1_rsp_valid", rsp_valid, 1'b1);
    chk("t1_rsp", {rsp_err, rsp_dat}, 33'h0);
    handshake();
    chk("t1_after_hs", {rsp_valid, cmd_ready, busy}, 3'b010);

    // ---- 2: read with 3 wait states ----
    issue(1'b0, 4'hF, 32'h3000_0008, 32'h0000_1111);
    for (int i = 1; i <= 4; i++) begin
      chk("t2_stb", {cyc, stb, we}, 3'b110);
      chk("t2_adr", adr, 32'h3000_0008);
      chk("t2_rsp_valid", rsp_valid, 1'b0);
      if (i == 4) begin
        ack   = 1'b1;
        dat_i = 32'h1234_5678;
      end else begin
        ack   = 1'b0;
      end
      tick();
    end
    ack   = 1'b0;
    dat_i = 32'h0;
    chk("t2_stb_low", {cyc, stb}, 2'b00);
    chk("t2_rsp_valid", rsp_valid, 1'b1);
    chk("t2_rsp", {rsp_err, rsp_dat}, {1'b0, 32'h1234_5678});
    handshake();

    // ---- 3: timeout after exactly 8 stb cycles ----
    issue(1'b0, 4'h3, 32'h3000_000C, 32'h0);
    for (int i = 1; i <= 8; i++) begin
      chk("t3_stb_high", {cyc, stb}, 2'b11);
      tick();
    end
    chk("t3_stb_low", {cyc, stb}, 2'b00);
    chk("t3_rsp_valid", rsp_valid, 1'b1);
    chk("t3_rsp", {rsp_err, rsp_dat}, {1'b1, 32'h0});
    handshake();
    issue(1'b1, 4'h1, 32'h3000_0010, 32'h0000_00AA);
    chk("t3_next_cmd", {cyc, stb, we}, 3'b111);
    chk("t3_next_adr", adr, 32'h3000_0010);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("t3_next_rsp", {rsp_valid, rsp_err}, 2'b10);
    handshake();

    // ---- 4: ack on the last timeout cycle wins ----
    issue(1'b0, 4'hF, 32'h3000_0014, 32'h0);
    for (int i = 1; i <= 8; i++) begin
      chk("t4_stb_high", {cyc, stb}, 2'b11);
      if (i == 8) begin
        ack   = 1'b1;
        dat_i = 32'hA5A5_0001;
      end else begin
        ack   = 1'b0;
      end
      tick();
    end
    ack   = 1'b0;
    dat_i = 32'h0;
    chk("t4_rsp", {rsp_valid, rsp_err, rsp_dat}, {2'b10, 32'hA5A5_0001});
    handshake();

    // ---- 5: response back-pressure ----
    issue(1'b0, 4'hF, 32'h3000_0018, 32'h0);
    ack   = 1'b1;
    dat_i = 32'hCAFE_F00D;
    tick();
    ack   = 1'b0;
    dat_i = 32'h0;
    cmd_valid = 1'b1;
    cmd_we    = 1'b0;
    cmd_adr   = 32'h3000_001C;
    for (int i = 0; i < 5; i++) begin
      chk("t5_rsp_hold", {rsp_valid, rsp_err, rsp_dat}, {2'b10, 32'hCAFE_F00D});
      chk("t5_no_accept", {cmd_ready, cyc, stb}, 3'b000);
      tick();
    end
    handshake();
    chk("t5_after_hs", {cmd_ready, rsp_valid, cyc}, 3'b100);
    tick();
    cmd_valid = 1'b0;
    chk("t5_accept", {cyc, stb}, 2'b11);
    chk("t5_accept_adr", adr, 32'h3000_001C);

    // ---- 6: async reset mid-cycle, then stray acks ----
    #2;
    rst = 1'b1;
    #1;
    chk("t6_async_drop", {cyc, stb, rsp_valid, busy, cmd_ready}, 5'b00000);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    chk("t6_idle", {cmd_ready, cyc, stb, rsp_valid}, 4'b1000);
    ack   = 1'b1;
    dat_i = 32'hFFFF_FFFF;
    tick();
    chk("t6_stray1", {cmd_ready, cyc, stb, rsp_valid, busy}, 5'b10000);
    chk("t6_stray1_dat", {rsp_err, rsp_dat}, 33'h0);
    ack = 1'b0;
    tick();
    ack = 1'b1;
    tick();
    ack   = 1'b0;
    dat_i = 32'h0;
    chk("t6_stray2", {cmd_ready, cyc, stb, rsp_valid, busy}, 5'b10000);
    tick();
    chk("t6_no_rsp", rsp_valid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/wb_cmd_master.md
Name: wb_cmd_master

Overview:
Wishbone classic single-access initiator. It accepts read and write commands on a valid/ready command port and runs one Wishbone bus cycle per command against the unigate slave port (wbs_* side). It returns the read data, or a timeout error, on a valid/ready response port. It sits in the test/bring-up path so that logic-analyzer or IO-driven sequencers can exercise the slave without the management SoC.

Parameters:
ADDR_W, 32, address width of cmd_adr / wbm_adr_o
DATA_W, 32, data width; SEL width = DATA_W/8
TIMEOUT, 255, max cycles with stb high before abort; 0 = never time out
TO_W, 8, timeout counter width; must hold TIMEOUT

Ports:
wb_clk_i  input  1  sole clock, rising edge
wb_rst_i  input  1  asynchronous active-high reset
cmd_valid  input  1  command offered
cmd_ready  output  1  command accepted when valid&ready
cmd_we  input  1  1=write, 0=read
cmd_sel  input  DATA_W/8  byte selects
cmd_adr  input  ADDR_W  address
cmd_dat  input  DATA_W  write data
rsp_valid  output  1  response available
rsp_ready  input  1  response consumed when valid&ready
rsp_dat  output  DATA_W  read data (0 for writes/errors)
rsp_err  output  1  1 = timed out
wbm_cyc_o  output  1  Wishbone CYC
wbm_stb_o  output  1  Wishbone STB
wbm_we_o  output  1  Wishbone WE
wbm_sel_o  output  DATA_W/8  Wishbone SEL
wbm_adr_o  output  ADDR_W  Wishbone ADR
wbm_dat_o  output  DATA_W  Wishbone write data
wbm_ack_i  input  1  Wishbone ACK
wbm_dat_i  input  DATA_W  Wishbone read data
busy  output  1  high in BUS or RESP

Behaviour:
- Reset (async, while wb_rst_i=1): state=IDLE; cmd_ready=0 during reset, 1 from the first clock after release; rsp_valid=0, rsp_dat=0, rsp_err=0, cyc=stb=we=0, sel=0, adr=0, dat_o=0, timeout counter=0, busy=0.
- All outputs are registered; cmd_ready=(state==IDLE), rsp_valid=(state==RESP).
- IDLE: on cmd_valid&cmd_ready, latch we/sel/adr/dat into the wbm_* registers, set cyc=stb=1, clear counter, go BUS. cyc/stb are first high the cycle after acceptance.
- BUS: cyc, stb, we, sel, adr and dat_o hold stable. Each cycle without ack, counter+1.
  - ack=1: capture rsp_dat = we ? 0 : wbm_dat_i, rsp_err=0, drop cyc/stb next edge, go RESP.
  - no ack and TIMEOUT!=0 and counter==TIMEOUT-1: rsp_dat=0, rsp_err=1, drop cyc/stb, go RESP. Stb-high duration on timeout is exactly TIMEOUT cycles.
  - ack in the same cycle as the timeout condition: ack wins, no error.
- RESP: rsp_valid=1; rsp_dat/rsp_err stable until rsp_valid&rsp_ready, then go IDLE. No new command is accepted in the same cycle as the handshake.
- Latency: accept at edge 0; stb high cycles 1..n; ack sampled at edge n; rsp_valid high from cycle n+1. With a zero-wait slave (ack at cycle 1), rsp_valid is high in cycle 2. Back-to-back throughput is 1 command per 3 cycles minimum.
- wbm_ack_i outside BUS is ignored, with no state change.
- Reset asserted mid-cycle: cyc/stb drop immediately (async) and the transaction is discarded, with no response.
- we=0 commands still drive wbm_dat_o with the latched cmd_dat (don't-care to the slave).
- Only classic single cycles; no burst, no RTY/ERR inputs.

Test Plan:
1. Write adr=0x3000_0004, dat=0xDEAD_BEEF, sel=0xF; slave acks on the 1st stb cycle -> cyc/stb high for exactly 1 cycle with those values and we=1; rsp_valid in cycle 2, rsp_dat=0, rsp_err=0.
2. Read adr=0x3000_0008; slave inserts 3 wait states, then returns 0x1234_5678 -> stb high 4 cycles with adr stable; rsp_dat=0x1234_5678, rsp_err=0.
3. TIMEOUT=8, slave never acks -> stb high exactly 8 cycles then low; rsp_err=1, rsp_dat=0; the next command is accepted normally.
4. Ack coincident with the last timeout cycle (ack on stb cycle 8, TIMEOUT=8) -> rsp_err=0, data captured.
5. rsp_ready held low 5 cycles after a read -> rsp_valid, rsp_dat and rsp_err stable; cmd_ready=0 and cmd_valid ignored; after the handshake, cmd_ready=1 next cycle.
6. wb_rst_i pulsed while stb high, plus stray ack pulses while IDLE -> cyc/stb/rsp_valid go 0 asynchronously; no response is produced; stray acks cause no output change.
